id_stage_fwd: RTL and testbench
===============================

Name: id_stage_fwd

Overview:
- Parametrised successor of the combinational decode stage.
- Decodes one MIPS32 instruction per cycle and issues regfile read requests.
- Forwards results from NUM_FWD younger pipeline stages; detects load-use hazards and stalls the fetch side.
- Holds its result in an internal ID/EX register with a valid/ready handshake, so downstream backpressure and flush are handled here.

Parameters:
- DW, 32, data/operand width; must be ≥32; immediates zero-extended to DW.
- AW, 5, register address width.
- NUM_FWD, 2, number of forwarding sources; index 0 = EX (youngest), 1 = MEM, and so on.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush_i  in  1  kill the instruction in ID and the ID/EX register.
- in_valid_i  in  1  pc_i/inst_i valid.
- in_ready_o  out  1  ID accepts the instruction this cycle.
- pc_i  in  32  instruction address.
- inst_i  in  32  instruction word.
- re1_o, re2_o  out  1 each  regfile read enables (combinational).
- raddr1_o, raddr2_o  out  AW each  regfile read addresses = inst_i[25:21], inst_i[20:16] (combinational).
- rdata1_i, rdata2_i  in  DW each  regfile read data, same cycle.
- fwd_we_i  in  NUM_FWD  per-source write enable.
- fwd_waddr_i  in  NUM_FWD*AW  per-source destination; source k at bits [k*AW +: AW].
- fwd_wdata_i  in  NUM_FWD*DW  per-source result.
- ex_is_load_i  in  1  source 0 holds a load (its data is not yet valid).
- out_valid_o  out  1  ID/EX register holds a valid instruction.
- out_ready_i  in  1  EX accepts the register contents.
- out_pc_o  out  32  registered pc.
- we_o  out  1  registered write enable.
- waddr_o  out  AW  registered destination.
- aluop_o  out  8  registered ALU op.
- alusel_o  out  3  registered result select.
- data1_o, data2_o  out  DW each  registered operands.
- invalid_o  out  1  registered reserved-instruction flag.

Behaviour:
- Reset (rst_n=0, async): all registered outputs 0; aluop_o = EXE_NOP_OP; alusel_o = EXE_RES_NOP.
- Decode (combinational from inst_i):
  - ORI/ANDI/XORI (op 001101/001100/001110): re1=1, re2=0; imm = zero-extended inst[15:0]; waddr = rt; we=1; aluop = OR/AND/XOR; alusel = LOGIC.
  - LUI (001111): re1=0, re2=0; imm = inst[15:0] shifted left 16; aluop = OR; waddr = rt; we=1.
  - SPECIAL (000000), funct 100100/100101/100110/100111: AND/OR/XOR/NOR; re1=re2=1; waddr = rd; we=1.
  - SPECIAL funct 000000: NOP; we=0; valid instruction.
  - Anything else: invalid=1, we=0, re1=re2=0, aluop NOP.
- Operand n selection, first match wins:
  - ren=0 → imm.
  - raddr==0 → 0 (never forwarded).
  - lowest k with fwd_we[k] and fwd_waddr[k]==raddr → fwd_wdata[k].
  - otherwise rdata.
- Hazard = in_valid_i & fwd_we_i[0] & ex_is_load_i & (re1 & raddr1==fwd_waddr[0]!=0, or the same test on port 2).
- Output register:
  - load_en = out_ready_i | ~out_valid_o.
  - in_ready_o = load_en & ~hazard & ~flush_i.
  - fire = in_valid_i & in_ready_o.
- Each rising edge:
  - flush_i → out_valid_o←0, we_o←0; other fields hold.
  - else load_en & fire → capture decode and operands; out_valid_o←1.
  - else load_en → bubble: out_valid_o←0, we_o←0, aluop_o←NOP.
  - else (EX stalled) → all outputs hold, regardless of forwarding changes.
- Load-use:
  - Exactly one bubble per hazard cycle.
  - The instruction is held upstream (in_ready_o=0) and re-decoded next cycle, when the load result arrives via source 1.
- Reset mid-operation clears out_valid_o immediately; no partial capture.
- No latency beyond one cycle: inst presented at edge N appears on outputs after edge N+1.

Decomposition:
- Shared package (defines header):
  - opcode/funct constants.
  - EXE_AND_OP 8'h24, EXE_OR_OP 8'h25, EXE_XOR_OP 8'h26, EXE_NOR_OP 8'h27, EXE_NOP_OP 8'h00.
  - EXE_RES_LOGIC 3'b001, EXE_RES_NOP 3'b000.
  - Enable/Disable/ZeroWord.
- Sub-module operand_mux (instantiated twice): ren, raddr, rdata, imm, fwd vectors → operand.
- Decoder and output register stay in id_stage_fwd.

Test Plan:
- ori $1,$0,0x1100 with no forwarding → after 1 edge: out_valid=1, we=1, waddr=1, aluop=0x25, data1=0, data2=0x00001100.
- or $3,$1,$2 with regfile $1=5, $2=9; fwd0 writes $1=0xA; fwd1 writes $2=0xB and $1=0xC → data1=0xA (index 0 wins), data2=0xB.
- Read $0 while fwd0 writes $0=0xFFFF → data1=0.
- fwd0 load to $4 with ex_is_load_i=1, then ori $5,$4,1 → in_ready_o=0 for 1 cycle, one bubble (out_valid=0, we=0); next cycle source 1 gives $4=0x77 → data1=0x77.
- out_ready_i=0 for 3 cycles with valid output → outputs stable, in_ready_o=0; flush_i pulse → out_valid=0, we=0 next edge.
- Opcode 111111 → invalid_o=1, we=0; assert rst_n=0 mid-stream → out_valid=0 with no clock edge.

Source files
------------

// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants for the forwarding ID stage: opcodes, functs,
// ALU operation / result-select encodings and common enable/zero values.
package id_stage_fwd_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FUNCT_NOP  = 6'b000000;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;

    typedef enum logic [7:0] {
        EXE_NOP_OP = 8'h00,
        EXE_AND_OP = 8'h24,
        EXE_OR_OP  = 8'h25,
        EXE_XOR_OP = 8'h26,
        EXE_NOR_OP = 8'h27
    } aluop_e;

    typedef enum logic [2:0] {
        EXE_RES_NOP   = 3'b000,
        EXE_RES_LOGIC = 3'b001
    } alusel_e;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/id_stage_fwd_operand_mux.sv
// Selects one source operand: immediate, hard-wired zero, the youngest
// matching forwarded result, or the regfile read data.
module id_stage_fwd_operand_mux
    import id_stage_fwd_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                  ren_i,
    input  logic [AW-1:0]         raddr_i,
    input  logic [DW-1:0]         rdata_i,
    input  logic [DW-1:0]         imm_i,
    input  logic [NUM_FWD-1:0]    fwd_we_i,
    input  logic [NUM_FWD*AW-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DW-1:0] fwd_wdata_i,
    output logic [DW-1:0]         operand_o
);

    always_comb begin
        // NOTE: default first so every path assigns operand_o and no latch is inferred.
        operand_o = rdata_i;
        // Walk from the oldest source down so the youngest match overrides.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we_i[k] && (fwd_waddr_i[k*AW +: AW] == raddr_i)) begin
                operand_o = fwd_wdata_i[k*DW +: DW];
            end
        end
        if (raddr_i == '0) operand_o = '0;
        if (!ren_i)        operand_o = imm_i;
    end

endmodule

// File: rtl/id_stage_fwd.sv
// MIPS32 logic-subset decode stage with operand forwarding, load-use stall
// and a valid/ready ID/EX output register.
module id_stage_fwd
    import id_stage_fwd_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           inst_i,
    output logic                  re1_o,
    output logic                  re2_o,
    output logic [AW-1:0]         raddr1_o,
    output logic [AW-1:0]         raddr2_o,
    input  logic [DW-1:0]         rdata1_i,
    input  logic [DW-1:0]         rdata2_i,
    input  logic [NUM_FWD-1:0]    fwd_we_i,
    input  logic [NUM_FWD*AW-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DW-1:0] fwd_wdata_i,
    input  logic                  ex_is_load_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_pc_o,
    output logic                  we_o,
    output logic [AW-1:0]         waddr_o,
    output logic [7:0]            aluop_o,
    output logic [2:0]            alusel_o,
    output logic [DW-1:0]         data1_o,
    output logic [DW-1:0]         data2_o,
    output logic                  invalid_o
);

    logic [5:0]    op, funct;
    logic          dec_we, dec_invalid;
    logic [AW-1:0] dec_waddr;
    aluop_e        dec_aluop;
    alusel_e       dec_alusel;
    logic [DW-1:0] dec_imm, op1, op2;
    logic          unused_shamt;

    assign op           = inst_i[31:26];
    assign funct        = inst_i[5:0];
    assign raddr1_o     = AW'(inst_i[25:21]);
    assign raddr2_o     = AW'(inst_i[20:16]);
    assign unused_shamt = ^inst_i[10:6];

    always_comb begin
        re1_o       = DISABLE;
        re2_o       = DISABLE;
        dec_we      = DISABLE;
        dec_invalid = ENABLE;
        dec_waddr   = AW'(inst_i[15:11]);
        dec_aluop   = EXE_NOP_OP;
        dec_alusel  = EXE_RES_NOP;
        dec_imm     = '0;
        unique case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                re1_o       = ENABLE;
                dec_we      = ENABLE;
                dec_invalid = DISABLE;
                dec_waddr   = raddr2_o;
                dec_imm     = DW'(inst_i[15:0]);
                dec_alusel  = EXE_RES_LOGIC;
                dec_aluop   = (op == OP_ORI)  ? EXE_OR_OP  :
                              (op == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
            end
            OP_LUI: begin
                dec_we      = ENABLE;
                dec_invalid = DISABLE;
                dec_waddr   = raddr2_o;
                dec_imm     = DW'({inst_i[15:0], 16'h0000});
                dec_aluop   = EXE_OR_OP;
                dec_alusel  = EXE_RES_LOGIC;
            end
            OP_SPECIAL: begin
                if (funct == FUNCT_NOP) begin
                    dec_invalid = DISABLE;
                end else if (funct inside {FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR}) begin
                    re1_o       = ENABLE;
                    re2_o       = ENABLE;
                    dec_we      = ENABLE;
                    dec_invalid = DISABLE;
                    dec_alusel  = EXE_RES_LOGIC;
                    dec_aluop   = (funct == FUNCT_AND) ? EXE_AND_OP :
                                  (funct == FUNCT_OR)  ? EXE_OR_OP  :
                                  (funct == FUNCT_XOR) ? EXE_XOR_OP : EXE_NOR_OP;
                end
            end
            default: ;
        endcase
    end

    id_stage_fwd_operand_mux #(.DW(DW), .AW(AW), .NUM_FWD(NUM_FWD)) u_mux1 (
        .ren_i(re1_o), .raddr_i(raddr1_o), .rdata_i(rdata1_i), .imm_i(dec_imm),
        .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
        .operand_o(op1)
    );

    id_stage_fwd_operand_mux #(.DW(DW), .AW(AW), .NUM_FWD(NUM_FWD)) u_mux2 (
        .ren_i(re2_o), .raddr_i(raddr2_o), .rdata_i(rdata2_i), .imm_i(dec_imm),
        .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
        .operand_o(op2)
    );

    // A load in EX has no data yet; stall if either live read port needs it.
    logic [AW-1:0] ex_waddr;
    logic          hazard, load_en, fire;

    assign ex_waddr   = fwd_waddr_i[AW-1:0];
    assign hazard     = in_valid_i && fwd_we_i[0] && ex_is_load_i &&
                        ((re1_o && raddr1_o == ex_waddr && raddr1_o != '0) ||
                         (re2_o && raddr2_o == ex_waddr && raddr2_o != '0));
    assign load_en    = out_ready_i || !out_valid_o;
    assign in_ready_o = load_en && !hazard && !flush_i;
    assign fire       = in_valid_i && in_ready_o;

    logic          valid_q, valid_d, we_q, we_d, invalid_q, invalid_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    aluop_q, aluop_d;
    logic [2:0]    alusel_q, alusel_d;
    logic [DW-1:0] data1_q, data1_d, data2_q, data2_d;

    always_comb begin
        valid_d   = valid_q;
        we_d      = we_q;
        invalid_d = invalid_q;
        pc_d      = pc_q;
        waddr_d   = waddr_q;
        aluop_d   = aluop_q;
        alusel_d  = alusel_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        if (flush_i) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (fire) begin
            valid_d   = 1'b1;
            we_d      = dec_we;
            invalid_d = dec_invalid;
            pc_d      = pc_i;
            waddr_d   = dec_waddr;
            aluop_d   = dec_aluop;
            alusel_d  = dec_alusel;
            data1_d   = op1;
            data2_d   = op2;
        end else if (load_en) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            aluop_d = EXE_NOP_OP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            invalid_q <= 1'b0;
            pc_q      <= ZERO_WORD;
            waddr_q   <= '0;
            aluop_q   <= EXE_NOP_OP;
            alusel_q  <= EXE_RES_NOP;
            data1_q   <= '0;
            data2_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            invalid_q <= invalid_d;
            pc_q      <= pc_d;
            waddr_q   <= waddr_d;
            aluop_q   <= aluop_d;
            alusel_q  <= alusel_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
        end
    end

    assign out_valid_o = valid_q;
    assign we_o        = we_q;
    assign invalid_o   = invalid_q;
    assign out_pc_o    = pc_q;
    assign waddr_o     = waddr_q;
    assign aluop_o     = aluop_q;
    assign alusel_o    = alusel_q;
    assign data1_o     = data1_q;
    assign data2_o     = data2_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: directed scenarios plus a randomized run against
// a cycle-level reference model built from the decode and forwarding rules.
module tb_id_stage_fwd;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NF = 2;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, ex_load, out_ready;
    logic [31:0]   pc, inst, out_pc;
    logic          re1, re2, out_valid, we, invalid;
    logic [AW-1:0] raddr1, raddr2, waddr;
    logic [DW-1:0] rdata1, rdata2, data1, data2;
    logic [NF-1:0] fwd_we;
    logic [NF*AW-1:0] fwd_waddr;
    logic [NF*DW-1:0] fwd_wdata;
    logic [7:0]    aluop;
    logic [2:0]    alusel;
    logic [AW-1:0] fa [NF];
    logic [DW-1:0] fd [NF];
    logic [31:0]   regs [32];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign fwd_waddr = {fa[1], fa[0]};
    assign fwd_wdata = {fd[1], fd[0]};
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
    end

    id_stage_fwd #(.DW(DW), .AW(AW), .NUM_FWD(NF)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .inst_i(inst), .re1_o(re1), .re2_o(re2), .raddr1_o(raddr1), .raddr2_o(raddr2),
        .rdata1_i(rdata1), .rdata2_i(rdata2), .fwd_we_i(fwd_we), .fwd_waddr_i(fwd_waddr),
        .fwd_wdata_i(fwd_wdata), .ex_is_load_i(ex_load), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_pc_o(out_pc), .we_o(we), .waddr_o(waddr), .aluop_o(aluop),
        .alusel_o(alusel), .data1_o(data1), .data2_o(data2), .invalid_o(invalid)
    );

    typedef struct {
        logic        re1, re2, we, inv;
        logic [4:0]  waddr;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        logic        valid, we, inv;
        logic [31:0] pc, d1, d2;
        logic [4:0]  waddr;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
    } exp_t;

    function automatic logic [31:0] mk_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] im);
        return {opc, rs, rt, im};
    endfunction

    // Decode table written out instruction by instruction.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        d = '{re1: 0, re2: 0, we: 0, inv: 1, waddr: ins[15:11], aluop: 8'h00, alusel: 3'b000, imm: 32'h0};
        if (ins[31:26] == 6'b001101) d = '{1, 0, 1, 0, ins[20:16], 8'h25, 3'b001, {16'h0, ins[15:0]}};
        if (ins[31:26] == 6'b001100) d = '{1, 0, 1, 0, ins[20:16], 8'h24, 3'b001, {16'h0, ins[15:0]}};
        if (ins[31:26] == 6'b001110) d = '{1, 0, 1, 0, ins[20:16], 8'h26, 3'b001, {16'h0, ins[15:0]}};
        if (ins[31:26] == 6'b001111) d = '{0, 0, 1, 0, ins[20:16], 8'h25, 3'b001, {ins[15:0], 16'h0}};
        if (ins[31:26] == 6'b000000) begin
            if (ins[5:0] == 6'b000000) d.inv = 0;
            if (ins[5:0] == 6'b100100) d = '{1, 1, 1, 0, ins[15:11], 8'h24, 3'b001, 32'h0};
            if (ins[5:0] == 6'b100101) d = '{1, 1, 1, 0, ins[15:11], 8'h25, 3'b001, 32'h0};
            if (ins[5:0] == 6'b100110) d = '{1, 1, 1, 0, ins[15:11], 8'h26, 3'b001, 32'h0};
            if (ins[5:0] == 6'b100111) d = '{1, 1, 1, 0, ins[15:11], 8'h27, 3'b001, 32'h0};
        end
        return d;
    endfunction

    function automatic logic [31:0] ref_operand(input logic ren, input logic [4:0] ra, input logic [31:0] imm);
        if (!ren) return imm;
        if (ra == 0) return 32'h0;
        for (int k = 0; k < NF; k++)
            if (fwd_we[k] && fa[k] == ra) return fd[k];
        return regs[ra];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; ex_load = 0; out_ready = 1; pc = 0; inst = 0;
        fwd_we = '0; fa[0] = 0; fa[1] = 0; fd[0] = 0; fd[1] = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we: got %0h want 0", we); end
        checks++; if (aluop !== 8'h00 || alusel !== 3'b000) begin failures++; $display("FAIL reset_op: got %0h/%0h want 0/0", aluop, alusel); end
        checks++; if ({out_pc, waddr, data1, data2, invalid} !== '0) begin failures++; $display("FAIL reset_fields: got pc=%0h wa=%0h d1=%0h d2=%0h inv=%0h want all 0", out_pc, waddr, data1, data2, invalid); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_ori();
        inst = mk_i(6'b001101, 5'd0, 5'd1, 16'h1100); pc = 32'h0000_0040; in_valid = 1;
        #1;
        checks++; if ({in_ready, re1, re2} !== 3'b110) begin failures++; $display("FAIL ori_comb: got rdy/re1/re2=%b want 110", {in_ready, re1, re2}); end
        tick();
        in_valid = 0;
        checks++; if ({out_valid, we, waddr} !== {1'b1, 1'b1, 5'd1}) begin failures++; $display("FAIL ori_ctrl: got v=%0h we=%0h wa=%0d want 1 1 1", out_valid, we, waddr); end
        checks++; if (aluop !== 8'h25 || alusel !== 3'b001) begin failures++; $display("FAIL ori_op: got %0h/%0h want 25/1", aluop, alusel); end
        checks++; if (data1 !== 32'h0 || data2 !== 32'h1100) begin failures++; $display("FAIL ori_data: got %0h/%0h want 0/1100", data1, data2); end
        checks++; if (out_pc !== 32'h40) begin failures++; $display("FAIL ori_pc: got %0h want 40", out_pc); end
    endtask

    task automatic test_fwd_priority();
        regs[1] = 5; regs[2] = 9;
        inst = mk_r(5'd1, 5'd2, 5'd3, 6'b100101); in_valid = 1;
        fwd_we = 2'b11; fa[0] = 1; fd[0] = 32'hA; fa[1] = 1; fd[1] = 32'hC;
        tick();
        checks++; if (data1 !== 32'hA || data2 !== 32'h9) begin failures++; $display("FAIL fwd_youngest: got %0h/%0h want a/9", data1, data2); end
        fa[1] = 2; fd[1] = 32'hB;
        tick();
        checks++; if (data1 !== 32'hA || data2 !== 32'hB) begin failures++; $display("FAIL fwd_both: got %0h/%0h want a/b", data1, data2); end
        fwd_we = 2'b00;
        tick();
        checks++; if (data1 !== 32'h5 || data2 !== 32'h9 || waddr !== 5'd3) begin failures++; $display("FAIL fwd_none: got %0h/%0h wa=%0d want 5/9 3", data1, data2, waddr); end
        in_valid = 0;
    endtask

    task automatic test_zero_reg();
        regs[0] = 32'hDEAD_0000;
        inst = mk_r(5'd0, 5'd2, 5'd3, 6'b100101); in_valid = 1;
        fwd_we = 2'b01; fa[0] = 0; fd[0] = 32'hFFFF; ex_load = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL zero_no_hazard: got %0h want 1", in_ready); end
        tick();
        checks++; if (data1 !== 32'h0 || data2 !== 32'h9) begin failures++; $display("FAIL zero_operand: got %0h/%0h want 0/9", data1, data2); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        inst = mk_i(6'b001101, 5'd4, 5'd5, 16'h0001); in_valid = 1;
        fwd_we = 2'b01; fa[0] = 4; fd[0] = 32'h1111; ex_load = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall: got %0h want 0", in_ready); end
        tick();
        checks++; if ({out_valid, we, aluop} !== 10'h0) begin failures++; $display("FAIL lu_bubble: got v=%0h we=%0h op=%0h want 0", out_valid, we, aluop); end
        fwd_we = 2'b10; fa[1] = 4; fd[1] = 32'h77; ex_load = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_release: got %0h want 1", in_ready); end
        tick();
        checks++; if ({out_valid, we, waddr} !== {1'b1, 1'b1, 5'd5} || data1 !== 32'h77 || data2 !== 32'h1) begin
            failures++; $display("FAIL lu_result: got v=%0h we=%0h wa=%0d d1=%0h d2=%0h want 1 1 5 77 1", out_valid, we, waddr, data1, data2);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure_flush();
        regs[1] = 32'h1234;
        inst = mk_i(6'b001110, 5'd1, 5'd6, 16'h00FF); in_valid = 1; pc = 32'h80;
        tick();
        out_ready = 0; inst = mk_i(6'b001101, 5'd2, 5'd7, 16'h5555); pc = 32'h84;
        fwd_we = 2'b11; fa[0] = 1; fd[0] = 32'hBAD; fa[1] = 2; fd[1] = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d: got %0h want 0", i, in_ready); end
            tick();
            checks++; if ({out_valid, we, waddr, aluop} !== {1'b1, 1'b1, 5'd6, 8'h26} || data1 !== 32'h1234 || data2 !== 32'hFF || out_pc !== 32'h80) begin
                failures++; $display("FAIL bp_hold%0d: got v=%0h we=%0h wa=%0d op=%0h d1=%0h d2=%0h pc=%0h want 1 1 6 26 1234 ff 80", i, out_valid, we, waddr, aluop, data1, data2, out_pc);
            end
        end
        flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %0h want 0", in_ready); end
        tick();
        checks++; if ({out_valid, we} !== 2'b00 || data1 !== 32'h1234 || aluop !== 8'h26) begin
            failures++; $display("FAIL flush_result: got v=%0h we=%0h d1=%0h op=%0h want 0 0 1234 26", out_valid, we, data1, aluop);
        end
        idle_inputs();
    endtask

    task automatic test_invalid_reset();
        inst = 32'hFFFF_FFFF; in_valid = 1;
        tick();
        in_valid = 0; out_ready = 0;
        checks++; if ({out_valid, invalid, we, aluop} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            failures++; $display("FAIL invalid_op: got v=%0h inv=%0h we=%0h op=%0h want 1 1 0 0", out_valid, invalid, we, aluop);
        end
        #2 rst_n = 0;
        #1;
        checks++; if ({out_valid, invalid, we} !== 3'b000) begin failures++; $display("FAIL async_reset: got v=%0h inv=%0h we=%0h want 0", out_valid, invalid, we); end
        tick();
        #2 rst_n = 1;
        idle_inputs();
    endtask

    task automatic test_random();
        exp_t m;
        dec_t d;
        logic [31:0] o1, o2, ins;
        logic hz, le, rdy;
        logic [4:0] rs, rt, rd;
        m = '{valid: 0, we: 0, inv: 0, pc: 0, d1: 0, d2: 0, waddr: 0, aluop: 0, alusel: 0};
        tick();
        for (int c = 0; c < 400; c++) begin
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
            ins = {6'($urandom), rs, rt, rd, 5'($urandom), 6'($urandom)};
            case ($urandom_range(0, 9))
                0: ins[31:26] = 6'b001101;
                1: ins[31:26] = 6'b001100;
                2: ins[31:26] = 6'b001110;
                3: ins[31:26] = 6'b001111;
                4, 5, 6, 7: begin ins[31:26] = 6'b000000; ins[5:0] = 6'b100100 + 6'($urandom_range(0, 3)); end
                8: begin ins[31:26] = 6'b000000; ins[5:0] = 6'b000000; end
                default: ;
            endcase
            inst = ins; pc = $urandom; regs[$urandom_range(0, 7)] = $urandom;
            in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0); ex_load = ($urandom_range(0, 3) == 0);
            fwd_we = 2'($urandom);
            for (int k = 0; k < NF; k++) begin fa[k] = 5'($urandom_range(0, 7)); fd[k] = $urandom; end
            #1;
            d  = ref_decode(ins);
            o1 = ref_operand(d.re1, rs, d.imm);
            o2 = ref_operand(d.re2, rt, d.imm);
            hz = in_valid && fwd_we[0] && ex_load &&
                 ((d.re1 && rs == fa[0] && rs != 0) || (d.re2 && rt == fa[0] && rt != 0));
            le  = out_ready || !m.valid;
            rdy = le && !hz && !flush;
            checks++; if ({in_ready, re1, re2, raddr1, raddr2} !== {rdy, d.re1, d.re2, rs, rt}) begin
                failures++; $display("FAIL rand_comb c=%0d: got rdy=%0h re=%0h%0h ra=%0d,%0d want %0h %0h%0h %0d,%0d", c, in_ready, re1, re2, raddr1, raddr2, rdy, d.re1, d.re2, rs, rt);
            end
            if (flush) begin
                m.valid = 0; m.we = 0;
            end else if (in_valid && rdy) begin
                m = '{valid: 1, we: d.we, inv: d.inv, pc: pc, d1: o1, d2: o2, waddr: d.waddr, aluop: d.aluop, alusel: d.alusel};
            end else if (le) begin
                m.valid = 0; m.we = 0; m.aluop = 8'h00;
            end
            tick();
            checks++; if ({out_valid, we, invalid, out_pc, data1, data2, waddr, aluop, alusel} !== {m.valid, m.we, m.inv, m.pc, m.d1, m.d2, m.waddr, m.aluop, m.alusel}) begin
                failures++;
                $display("FAIL rand_regs c=%0d: got v=%0h we=%0h inv=%0h pc=%0h d1=%0h d2=%0h wa=%0d op=%0h sel=%0h want %0h %0h %0h %0h %0h %0h %0d %0h %0h", c,
                         out_valid, we, invalid, out_pc, data1, data2, waddr, aluop, alusel,
                         m.valid, m.we, m.inv, m.pc, m.d1, m.d2, m.waddr, m.aluop, m.alusel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_fwd_priority();
        test_zero_reg();
        test_load_use();
        test_backpressure_flush();
        test_invalid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
